// File: rtl/fsm_rotulagem.sv
// fsm_rotulagem: labelling-station slave FSM on the master's cmd_iniciar /
// tarefa_concluida 4-phase handshake. Fires the labeller, waits for the
// label-applied sensor, reports completion and tracks label stock.
// Define ROTULO_TIMEOUT_EN to include the jam watchdog and the FALHA state.
module fsm_rotulagem #(
  parameter int unsigned ESTOQUE_INICIAL = 50,
  parameter int unsigned ESTOQUE_MAX     = 99,
  parameter int unsigned RECARGA         = 10,
  parameter int unsigned TIMEOUT_CICLOS  = 50_000_000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       cmd_iniciar,
  input  logic       sensor_rotulo,
  input  logic       sw_repor,
  output logic       rotulador_ativo,
  output logic       tarefa_concluida,
  output logic       falha_rotulo,
  output logic       alarme_rotulo,
  output logic [6:0] estoque_valor
);

  localparam int unsigned EST_W = 7;
  localparam int unsigned SUM_W = 8;

  localparam logic [2:0] OCIOSO         = 3'd0;
  localparam logic [2:0] ESPERA_ESTOQUE = 3'd1;
  localparam logic [2:0] APLICANDO      = 3'd2;
  localparam logic [2:0] CONCLUIDO      = 3'd3;
`ifdef ROTULO_TIMEOUT_EN
  localparam logic [2:0] FALHA          = 3'd4;
  localparam int unsigned WD_W = (TIMEOUT_CICLOS > 2) ? $clog2(TIMEOUT_CICLOS) : 1;
`endif

  // Elaboration-time sanity check on the stock and timeout parameters
  if (ESTOQUE_INICIAL > ESTOQUE_MAX || ESTOQUE_MAX > 127 || TIMEOUT_CICLOS < 2) begin : g_param_check
    $error("fsm_rotulagem: invalid parameter set");
  end

  logic [2:0]       state, state_nxt;
  logic             sensor_s1, sensor_s2;
  logic             repor_s1, repor_s2, repor_q;
  logic             repor_pulso;
  logic             consome;
  logic [SUM_W-1:0] soma;
  logic [EST_W-1:0] estoque_nxt;
  logic             concluida_nxt;
`ifdef ROTULO_TIMEOUT_EN
  logic [WD_W-1:0]  wd;
  logic             wd_fim;
`endif

  // 2-FF synchronisers for the asynchronous switches, plus refill edge history
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sensor_s1 <= 1'b0;
      sensor_s2 <= 1'b0;
      repor_s1  <= 1'b0;
      repor_s2  <= 1'b0;
      repor_q   <= 1'b0;
    end else begin
      sensor_s1 <= sensor_rotulo;
      sensor_s2 <= sensor_s1;
      repor_s1  <= sw_repor;
      repor_s2  <= repor_s1;
      repor_q   <= repor_s2;
    end
  end

  assign repor_pulso = repor_s2 & ~repor_q;

`ifdef ROTULO_TIMEOUT_EN
  assign wd_fim = (wd == WD_W'(TIMEOUT_CICLOS - 1));

  // Watchdog: runs only while the FSM stays in APLICANDO, zero otherwise
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wd <= '0;
    end else if (state == APLICANDO && state_nxt == APLICANDO) begin
      wd <= wd + WD_W'(1);
    end else begin
      wd <= '0;
    end
  end
`endif

  // Next-state decode; the sensor wins over a watchdog expiry on the same edge
  always_comb begin
    state_nxt = state;
    consome   = 1'b0;
    case (state)
      OCIOSO: begin
        if (cmd_iniciar) begin
          state_nxt = (estoque_valor != '0) ? APLICANDO : ESPERA_ESTOQUE;
        end
      end
      ESPERA_ESTOQUE: begin
        if (!cmd_iniciar)              state_nxt = OCIOSO;
        else if (estoque_valor != '0)  state_nxt = APLICANDO;
      end
      APLICANDO: begin
        if (!cmd_iniciar) begin
          state_nxt = OCIOSO;
        end else if (sensor_s2) begin
          state_nxt = CONCLUIDO;
          consome   = 1'b1;
        end
`ifdef ROTULO_TIMEOUT_EN
        else if (wd_fim) begin
          state_nxt = FALHA;
        end
`endif
      end
      CONCLUIDO: begin
        if (!cmd_iniciar) state_nxt = OCIOSO;
      end
`ifdef ROTULO_TIMEOUT_EN
      FALHA: begin
        if (!cmd_iniciar) state_nxt = OCIOSO;
      end
`endif
      default: state_nxt = OCIOSO;
    endcase
  end

  // Stock update: decrement and refill may coincide; result saturates at the ceiling
  always_comb begin
    soma = SUM_W'(estoque_valor);
    if (consome)     soma = soma - SUM_W'(1);
    if (repor_pulso) soma = soma + SUM_W'(RECARGA);
    estoque_nxt = (soma > SUM_W'(ESTOQUE_MAX)) ? EST_W'(ESTOQUE_MAX) : EST_W'(soma);
  end

`ifdef ROTULO_TIMEOUT_EN
  assign concluida_nxt = (state_nxt == CONCLUIDO) || (state_nxt == FALHA);
`else
  assign concluida_nxt = (state_nxt == CONCLUIDO);
`endif

  // State, stock and registered Moore outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state            <= OCIOSO;
      estoque_valor    <= EST_W'(ESTOQUE_INICIAL);
      alarme_rotulo    <= (ESTOQUE_INICIAL == 0);
      rotulador_ativo  <= 1'b0;
      tarefa_concluida <= 1'b0;
    end else begin
      state            <= state_nxt;
      estoque_valor    <= estoque_nxt;
      alarme_rotulo    <= (estoque_nxt == '0);
      rotulador_ativo  <= (state_nxt == APLICANDO);
      tarefa_concluida <= concluida_nxt;
    end
  end

`ifdef ROTULO_TIMEOUT_EN
  // Jam flag, meaningful while tarefa_concluida is high
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      falha_rotulo <= 1'b0;
    end else begin
      falha_rotulo <= (state_nxt == FALHA);
    end
  end
`else
  assign falha_rotulo = 1'b0;
`endif

endmodule

// File: tb/tb_fsm_rotulagem.sv
// Self-checking bench for fsm_rotulagem (stock 2 at reset, 16-cycle watchdog).
module tb_fsm_rotulagem;

  localparam int unsigned EST_INI = 2;
  localparam int unsigned EST_MAX = 99;
  localparam int unsigned REC     = 10;
  localparam int unsigned TMO     = 16;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       cmd_iniciar = 1'b0;
  logic       sensor_rotulo = 1'b0;
  logic       sw_repor = 1'b0;
  logic       rotulador_ativo, tarefa_concluida, falha_rotulo, alarme_rotulo;
  logic [6:0] estoque_valor;

  int checks = 0;
  int errors = 0;
  int mdl_est;

  typedef struct {
    int   est;
    logic falha;
  } exp_t;
  exp_t exp_q[$];

  fsm_rotulagem #(
    .ESTOQUE_INICIAL(EST_INI),
    .ESTOQUE_MAX    (EST_MAX),
    .RECARGA        (REC),
    .TIMEOUT_CICLOS (TMO)
  ) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .cmd_iniciar     (cmd_iniciar),
    .sensor_rotulo   (sensor_rotulo),
    .sw_repor        (sw_repor),
    .rotulador_ativo (rotulador_ativo),
    .tarefa_concluida(tarefa_concluida),
    .falha_rotulo    (falha_rotulo),
    .alarme_rotulo   (alarme_rotulo),
    .estoque_valor   (estoque_valor)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not finish, checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input int max_cyc, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < max_cyc && !seen; i++) begin
      tick(1);
      if (tarefa_concluida === 1'b1) seen = 1'b1;
    end
  endtask

  function automatic int sat(input int v);
    return (v > int'(EST_MAX)) ? int'(EST_MAX) : v;
  endfunction

  // Full job through the handshake; optional refill synchronised with the sensor
  task automatic run_job(input string name, input bit with_refill);
    exp_t e;
    bit   seen;
    cmd_iniciar = 1'b1;
    tick(1);
    checks++;
    if (rotulador_ativo !== 1'b1) begin
      errors++;
      $display("FAIL %s_start: rotulador_ativo=%b expected 1", name, rotulador_ativo);
    end
    mdl_est = sat(mdl_est - 1 + (with_refill ? int'(REC) : 0));
    exp_q.push_back('{mdl_est, 1'b0});
    sensor_rotulo = 1'b1;
    if (with_refill) sw_repor = 1'b1;
    wait_done(6, seen);
    e = exp_q.pop_front();
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL %s_done: tarefa_concluida never rose, expected 1 within 6 cycles", name);
    end else begin
      checks++;
      if (estoque_valor !== 7'(e.est) || falha_rotulo !== e.falha) begin
        errors++;
        $display("FAIL %s_result: estoque=%0d falha=%b expected estoque=%0d falha=%b",
                 name, estoque_valor, falha_rotulo, e.est, e.falha);
      end
      checks++;
      if (alarme_rotulo !== (e.est == 0)) begin
        errors++;
        $display("FAIL %s_alarme: alarme=%b expected %b", name, alarme_rotulo, (e.est == 0));
      end
    end
    cmd_iniciar   = 1'b0;
    sensor_rotulo = 1'b0;
    sw_repor      = 1'b0;
    tick(1);
    checks++;
    if (tarefa_concluida !== 1'b0 || rotulador_ativo !== 1'b0) begin
      errors++;
      $display("FAIL %s_release: concluida=%b rotulador=%b expected 0 0", name, tarefa_concluida, rotulador_ativo);
    end
    tick(2);
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    tick(2);
    checks++;
    if (rotulador_ativo !== 1'b0 || tarefa_concluida !== 1'b0 || falha_rotulo !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: rotulador=%b concluida=%b falha=%b expected 0 0 0",
               rotulador_ativo, tarefa_concluida, falha_rotulo);
    end
    checks++;
    if (estoque_valor !== 7'(EST_INI) || alarme_rotulo !== 1'b0) begin
      errors++;
      $display("FAIL reset_stock: estoque=%0d alarme=%b expected %0d 0", estoque_valor, alarme_rotulo, EST_INI);
    end
    reset_n = 1'b1;
    mdl_est = int'(EST_INI);
    tick(1);
  endtask

  task automatic test_basic_job();
    exp_t e;
    cmd_iniciar = 1'b1;
    tick(1);
    checks++;
    if (rotulador_ativo !== 1'b1) begin
      errors++;
      $display("FAIL basic_cmd_latency: rotulador=%b expected 1", rotulador_ativo);
    end
    mdl_est = mdl_est - 1;
    exp_q.push_back('{mdl_est, 1'b0});
    sensor_rotulo = 1'b1;
    tick(2);
    checks++;
    if (tarefa_concluida !== 1'b0) begin
      errors++;
      $display("FAIL basic_early_done: concluida=%b expected 0", tarefa_concluida);
    end
    tick(1);
    e = exp_q.pop_front();
    checks++;
    if (tarefa_concluida !== 1'b1 || estoque_valor !== 7'(e.est) || falha_rotulo !== e.falha) begin
      errors++;
      $display("FAIL basic_done: concluida=%b estoque=%0d falha=%b expected 1 %0d %b",
               tarefa_concluida, estoque_valor, falha_rotulo, e.est, e.falha);
    end
    checks++;
    if (rotulador_ativo !== 1'b0) begin
      errors++;
      $display("FAIL basic_rotulador_off: rotulador=%b expected 0", rotulador_ativo);
    end
    cmd_iniciar   = 1'b0;
    sensor_rotulo = 1'b0;
    tick(1);
    checks++;
    if (tarefa_concluida !== 1'b0) begin
      errors++;
      $display("FAIL basic_release: concluida=%b expected 0", tarefa_concluida);
    end
    tick(2);
  endtask

  task automatic test_stock_empty();
    exp_t e;
    bit   seen;
    run_job("empty_job", 1'b0);
    cmd_iniciar = 1'b1;
    tick(3);
    checks++;
    if (rotulador_ativo !== 1'b0 || tarefa_concluida !== 1'b0 || alarme_rotulo !== 1'b1) begin
      errors++;
      $display("FAIL empty_wait: rotulador=%b concluida=%b alarme=%b expected 0 0 1",
               rotulador_ativo, tarefa_concluida, alarme_rotulo);
    end
    sw_repor = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 4 && !seen; i++) begin
      tick(1);
      if (rotulador_ativo === 1'b1) seen = 1'b1;
    end
    mdl_est = sat(mdl_est + int'(REC));
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL empty_release: rotulador stayed 0, expected 1 within 4 edges");
    end
    checks++;
    if (estoque_valor !== 7'(mdl_est) || alarme_rotulo !== 1'b0) begin
      errors++;
      $display("FAIL empty_refill: estoque=%0d alarme=%b expected %0d 0", estoque_valor, alarme_rotulo, mdl_est);
    end
    mdl_est = mdl_est - 1;
    exp_q.push_back('{mdl_est, 1'b0});
    sensor_rotulo = 1'b1;
    wait_done(6, seen);
    e = exp_q.pop_front();
    checks++;
    if (!seen || estoque_valor !== 7'(e.est)) begin
      errors++;
      $display("FAIL empty_job_after_refill: seen=%b estoque=%0d expected 1 %0d", seen, estoque_valor, e.est);
    end
    cmd_iniciar   = 1'b0;
    sensor_rotulo = 1'b0;
    sw_repor      = 1'b0;
    tick(3);
  endtask

  task automatic test_watchdog();
`ifdef ROTULO_TIMEOUT_EN
    exp_t e;
    cmd_iniciar = 1'b1;
    tick(1);
    exp_q.push_back('{mdl_est, 1'b1});
    tick(int'(TMO) - 1);
    checks++;
    if (tarefa_concluida !== 1'b0 || rotulador_ativo !== 1'b1) begin
      errors++;
      $display("FAIL wd_early: concluida=%b rotulador=%b expected 0 1", tarefa_concluida, rotulador_ativo);
    end
    tick(1);
    e = exp_q.pop_front();
    checks++;
    if (tarefa_concluida !== 1'b1 || falha_rotulo !== e.falha || estoque_valor !== 7'(e.est)) begin
      errors++;
      $display("FAIL wd_falha: concluida=%b falha=%b estoque=%0d expected 1 %b %0d",
               tarefa_concluida, falha_rotulo, estoque_valor, e.falha, e.est);
    end
    checks++;
    if (rotulador_ativo !== 1'b0) begin
      errors++;
      $display("FAIL wd_rotulador: rotulador=%b expected 0", rotulador_ativo);
    end
    cmd_iniciar = 1'b0;
    tick(1);
    checks++;
    if (falha_rotulo !== 1'b0 || tarefa_concluida !== 1'b0) begin
      errors++;
      $display("FAIL wd_release: falha=%b concluida=%b expected 0 0", falha_rotulo, tarefa_concluida);
    end
    tick(2);
`else
    cmd_iniciar = 1'b1;
    tick(1000);
    checks++;
    if (rotulador_ativo !== 1'b1 || falha_rotulo !== 1'b0 || tarefa_concluida !== 1'b0) begin
      errors++;
      $display("FAIL nowd_hold: rotulador=%b falha=%b concluida=%b expected 1 0 0",
               rotulador_ativo, falha_rotulo, tarefa_concluida);
    end
    cmd_iniciar = 1'b0;
    tick(1);
    checks++;
    if (rotulador_ativo !== 1'b0 || estoque_valor !== 7'(mdl_est)) begin
      errors++;
      $display("FAIL nowd_abort: rotulador=%b estoque=%0d expected 0 %0d", rotulador_ativo, estoque_valor, mdl_est);
    end
    tick(2);
`endif
  endtask

  task automatic test_abort();
    cmd_iniciar = 1'b1;
    tick(1);
    cmd_iniciar = 1'b0;
    tick(1);
    checks++;
    if (rotulador_ativo !== 1'b0 || tarefa_concluida !== 1'b0 || estoque_valor !== 7'(mdl_est)) begin
      errors++;
      $display("FAIL abort_aplicando: rotulador=%b concluida=%b estoque=%0d expected 0 0 %0d",
               rotulador_ativo, tarefa_concluida, estoque_valor, mdl_est);
    end
    tick(2);
  endtask

  task automatic test_back_to_back();
    exp_t e;
    bit   seen;
    cmd_iniciar = 1'b1;
    for (int j = 0; j < 2; j++) begin
      tick(1);
      checks++;
      if (rotulador_ativo !== 1'b1) begin
        errors++;
        $display("FAIL b2b_start%0d: rotulador=%b expected 1", j, rotulador_ativo);
      end
      mdl_est = mdl_est - 1;
      exp_q.push_back('{mdl_est, 1'b0});
      sensor_rotulo = 1'b1;
      wait_done(6, seen);
      e = exp_q.pop_front();
      checks++;
      if (!seen || estoque_valor !== 7'(e.est)) begin
        errors++;
        $display("FAIL b2b_done%0d: seen=%b estoque=%0d expected 1 %0d", j, seen, estoque_valor, e.est);
      end
      cmd_iniciar   = 1'b0;
      sensor_rotulo = 1'b0;
      tick(1);
      cmd_iniciar = (j == 0);
    end
    tick(2);
  endtask

  task automatic test_refill_saturation();
    run_job("tie_job", 1'b1);
    for (int k = 0; k < 10; k++) begin
      sw_repor = 1'b1;
      tick(3);
      sw_repor = 1'b0;
      tick(3);
      mdl_est = sat(mdl_est + int'(REC));
      checks++;
      if (estoque_valor !== 7'(mdl_est) || alarme_rotulo !== 1'b0) begin
        errors++;
        $display("FAIL refill%0d: estoque=%0d alarme=%b expected %0d 0", k, estoque_valor, alarme_rotulo, mdl_est);
      end
    end
    run_job("tie_sat_job", 1'b1);
  endtask

  task automatic test_async_reset();
    cmd_iniciar = 1'b1;
    tick(1);
    #2;
    reset_n = 1'b0;
    #1;
    checks++;
    if (rotulador_ativo !== 1'b0 || tarefa_concluida !== 1'b0) begin
      errors++;
      $display("FAIL areset_outputs: rotulador=%b concluida=%b expected 0 0", rotulador_ativo, tarefa_concluida);
    end
    checks++;
    if (estoque_valor !== 7'(EST_INI) || alarme_rotulo !== 1'b0) begin
      errors++;
      $display("FAIL areset_stock: estoque=%0d alarme=%b expected %0d 0", estoque_valor, alarme_rotulo, EST_INI);
    end
    cmd_iniciar = 1'b0;
    tick(1);
    reset_n = 1'b1;
    mdl_est = int'(EST_INI);
    tick(1);
    run_job("drain_a", 1'b0);
    run_job("drain_b", 1'b0);
    cmd_iniciar = 1'b1;
    tick(3);
    checks++;
    if (rotulador_ativo !== 1'b0) begin
      errors++;
      $display("FAIL espera_hold: rotulador=%b expected 0", rotulador_ativo);
    end
    cmd_iniciar = 1'b0;
    tick(2);
    checks++;
    if (tarefa_concluida !== 1'b0 || estoque_valor !== 7'(mdl_est) || alarme_rotulo !== 1'b1) begin
      errors++;
      $display("FAIL espera_abort: concluida=%b estoque=%0d alarme=%b expected 0 %0d 1",
               tarefa_concluida, estoque_valor, alarme_rotulo, mdl_est);
    end
    sw_repor = 1'b1;
    tick(3);
    sw_repor = 1'b0;
    tick(3);
    mdl_est = sat(mdl_est + int'(REC));
    checks++;
    if (estoque_valor !== 7'(mdl_est)) begin
      errors++;
      $display("FAIL post_abort_refill: estoque=%0d expected %0d", estoque_valor, mdl_est);
    end
    run_job("post_abort_job", 1'b0);
  endtask

  initial begin
    test_reset();
    test_basic_job();
    test_stock_empty();
    test_watchdog();
    test_abort();
    test_back_to_back();
    test_refill_saturation();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
